// File: rtl/group1_sequencer.sv
// Instruction sequencer for the 6502-style group-1 opcodes (cc=01): walks each
// instruction through its addressing cycles and strobes the ALU or a store.
module group1_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [7:0]  d_in,
    input  logic [7:0]  acc_in,
    input  logic [7:0]  x_in,
    output logic [15:0] addr,
    output logic [7:0]  d_out,
    output logic        we,
    output logic        exec,
    output logic [2:0]  alu_op,
    output logic [7:0]  operand,
    output logic        sync,
    output logic        illegal
);

    typedef enum logic [2:0] {
        FETCH,
        OPER,
        ADDRH,
        INDEX,
        MEM,
        HALT
    } state_t;

    localparam logic [2:0] MODE_ZP  = 3'b001;
    localparam logic [2:0] MODE_IMM = 3'b010;
    localparam logic [2:0] MODE_ABS = 3'b011;
    localparam logic [2:0] MODE_ZPX = 3'b101;
    localparam logic [2:0] OP_STA   = 3'b100;

    state_t      state;
    logic [15:0] pc;
    logic [15:0] ea;
    logic [7:0]  opcode;

    // STA immediate would be a store to nowhere, so it is rejected with the
    // unsupported addressing modes.
    function automatic logic is_legal(input logic [7:0] op);
        logic mode_ok;
        mode_ok = (op[4:2] == MODE_ZP) || (op[4:2] == MODE_IMM) ||
                  (op[4:2] == MODE_ABS) || (op[4:2] == MODE_ZPX);
        return (op[1:0] == 2'b01) && mode_ok && (op != 8'h89);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= FETCH;
            pc     <= RESET_PC;
            ea     <= 16'h0000;
            opcode <= 8'h00;
        end else if (rdy) begin
            case (state)
                FETCH: begin
                    opcode <= d_in;
                    pc     <= pc + 16'd1;
                    state  <= is_legal(d_in) ? OPER : HALT;
                end
                OPER: begin
                    pc <= pc + 16'd1;
                    case (opcode[4:2])
                        MODE_IMM: state <= FETCH;
                        MODE_ZP: begin
                            ea    <= {8'h00, d_in};
                            state <= MEM;
                        end
                        MODE_ABS: begin
                            ea[7:0] <= d_in;
                            state   <= ADDRH;
                        end
                        MODE_ZPX: begin
                            ea[7:0] <= d_in;
                            state   <= INDEX;
                        end
                        default: state <= HALT;
                    endcase
                end
                ADDRH: begin
                    ea[15:8] <= d_in;
                    pc       <= pc + 16'd1;
                    state    <= MEM;
                end
                INDEX: begin
                    // Zero-page indexing wraps within page zero.
                    ea    <= {8'h00, ea[7:0] + x_in};
                    state <= MEM;
                end
                MEM:     state <= FETCH;
                HALT:    state <= HALT;
                default: state <= HALT;
            endcase
        end
    end

    always_comb begin
        addr    = pc;
        we      = 1'b0;
        exec    = 1'b0;
        d_out   = 8'h00;
        operand = 8'h00;
        case (state)
            OPER: begin
                if (rdy && opcode[4:2] == MODE_IMM) begin
                    exec    = 1'b1;
                    operand = d_in;
                end
            end
            INDEX: addr = {8'h00, ea[7:0]};
            MEM: begin
                addr = ea;
                if (rdy) begin
                    if (opcode[7:5] == OP_STA) begin
                        we    = 1'b1;
                        d_out = acc_in;
                    end else begin
                        exec    = 1'b1;
                        operand = d_in;
                    end
                end
            end
            default: ;
        endcase
    end

    assign alu_op  = opcode[7:5];
    assign sync    = (state == FETCH);
    assign illegal = (state == HALT);

endmodule

// File: tb/tb_group1_sequencer.sv
// Directed bench for group1_sequencer: one instance at RESET_PC=0000 for the
// main programs and one at FFFF for the program-counter wrap.
module tb_group1_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic [7:0]  acc_in = 8'h00;
    logic [7:0]  x_in = 8'h00;

    logic [7:0]  mem   [0:65535];
    logic [7:0]  mem_w [0:65535];

    logic [7:0]  d_in, d_out, operand;
    logic [15:0] addr;
    logic        we, exec, sync, illegal;
    logic [2:0]  alu_op;

    logic [7:0]  w_d_in, w_d_out, w_operand;
    logic [15:0] w_addr;
    logic        w_we, w_exec, w_sync, w_illegal;
    logic [2:0]  w_alu_op;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    assign d_in   = mem[addr];
    assign w_d_in = mem_w[w_addr];

    group1_sequencer #(.RESET_PC(16'h0000)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .d_in(d_in), .acc_in(acc_in),
        .x_in(x_in), .addr(addr), .d_out(d_out), .we(we), .exec(exec),
        .alu_op(alu_op), .operand(operand), .sync(sync), .illegal(illegal)
    );

    group1_sequencer #(.RESET_PC(16'hFFFF)) dut_wrap (
        .clk(clk), .rst(rst), .rdy(rdy), .d_in(w_d_in), .acc_in(acc_in),
        .x_in(x_in), .addr(w_addr), .d_out(w_d_out), .we(w_we), .exec(w_exec),
        .alu_op(w_alu_op), .operand(w_operand), .sync(w_sync), .illegal(w_illegal)
    );

    task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance one clock and sample 1 time unit past the rising edge.
    task automatic apply_stimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        rst = 1'b0;
        rdy = 1'b1;
        apply_stimulus();
        rst = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i]   = 8'h00;
            mem_w[i] = 8'h00;
        end
        apply_stimulus();

        // Reset state
        check_output("rst_addr", addr, 16'h0000);
        check_output("rst_we", 16'(we), 16'h0);
        check_output("rst_exec", 16'(exec), 16'h0);
        check_output("rst_illegal", 16'(illegal), 16'h0);
        check_output("rst_d_out", 16'(d_out), 16'h00);
        check_output("rst_alu_op", 16'(alu_op), 16'h0);
        check_output("rst_operand", 16'(operand), 16'h00);
        check_output("rst_sync", 16'(sync), 16'h1);

        // ADC #$05
        mem[0] = 8'h69; mem[1] = 8'h05;
        rst = 1'b1;
        check_output("imm_c1_addr", addr, 16'h0000);
        apply_stimulus();
        check_output("imm_c2_exec", 16'(exec), 16'h1);
        check_output("imm_c2_aluop", 16'(alu_op), 16'h3);
        check_output("imm_c2_operand", 16'(operand), 16'h05);
        check_output("imm_c2_we", 16'(we), 16'h0);
        check_output("imm_c2_sync", 16'(sync), 16'h0);
        apply_stimulus();
        check_output("imm_c3_sync", 16'(sync), 16'h1);
        check_output("imm_c3_addr", addr, 16'h0002);

        // ADC $F0,X with X=$20 wraps to $0010
        rst = 1'b0;
        mem[0] = 8'h75; mem[1] = 8'hF0; mem[16'h0010] = 8'h7E;
        x_in = 8'h20;
        reset_pulse();
        apply_stimulus();
        check_output("zpx_c2_addr", addr, 16'h0001);
        check_output("zpx_c2_exec", 16'(exec), 16'h0);
        apply_stimulus();
        check_output("zpx_c3_addr", addr, 16'h00F0);
        check_output("zpx_c3_exec", 16'(exec), 16'h0);
        apply_stimulus();
        check_output("zpx_c4_addr", addr, 16'h0010);
        check_output("zpx_c4_exec", 16'(exec), 16'h1);
        check_output("zpx_c4_operand", 16'(operand), 16'h7E);
        apply_stimulus();
        check_output("zpx_c5_sync", 16'(sync), 16'h1);
        check_output("zpx_c5_addr", addr, 16'h0002);

        // EOR $40
        mem[0] = 8'h45; mem[1] = 8'h40; mem[16'h0040] = 8'h3C;
        reset_pulse();
        apply_stimulus();
        check_output("zp_c2_exec", 16'(exec), 16'h0);
        apply_stimulus();
        check_output("zp_c3_addr", addr, 16'h0040);
        check_output("zp_c3_exec", 16'(exec), 16'h1);
        check_output("zp_c3_aluop", 16'(alu_op), 16'h2);
        check_output("zp_c3_operand", 16'(operand), 16'h3C);

        // STA $1234
        mem[0] = 8'h8D; mem[1] = 8'h34; mem[2] = 8'h12;
        acc_in = 8'hAA;
        reset_pulse();
        apply_stimulus();
        apply_stimulus();
        check_output("sta_c3_addr", addr, 16'h0002);
        check_output("sta_c3_we", 16'(we), 16'h0);
        apply_stimulus();
        check_output("sta_c4_addr", addr, 16'h1234);
        check_output("sta_c4_we", 16'(we), 16'h1);
        check_output("sta_c4_d_out", 16'(d_out), 16'h00AA);
        check_output("sta_c4_exec", 16'(exec), 16'h0);
        apply_stimulus();
        check_output("sta_c5_addr", addr, 16'h0003);
        check_output("sta_c5_we", 16'(we), 16'h0);
        check_output("sta_c5_d_out", 16'(d_out), 16'h00);

        // Reset asserted during the STA write cycle aborts the store at once
        reset_pulse();
        apply_stimulus();
        apply_stimulus();
        apply_stimulus();
        rst = 1'b0;
        #1;
        check_output("abort_we", 16'(we), 16'h0);
        check_output("abort_addr", addr, 16'h0000);
        check_output("abort_sync", 16'(sync), 16'h1);
        apply_stimulus();
        rst = 1'b1;
        apply_stimulus();
        check_output("abort_refetch_addr", addr, 16'h0001);

        // STA immediate is illegal and halts
        mem[0] = 8'h89;
        reset_pulse();
        apply_stimulus();
        check_output("ill_flag", 16'(illegal), 16'h1);
        check_output("ill_addr", addr, 16'h0001);
        for (int i = 0; i < 10; i++) begin
            apply_stimulus();
            check_output($sformatf("halt%0d_strobes", i), {14'h0, we, exec}, 16'h0);
            check_output($sformatf("halt%0d_illegal", i), 16'(illegal), 16'h1);
        end
        rst = 1'b0;
        #1;
        check_output("ill_rst_flag", 16'(illegal), 16'h0);
        check_output("ill_rst_addr", addr, 16'h0000);
        apply_stimulus();

        // Unsupported addressing mode (ADC (zp,X)) is illegal too
        mem[0] = 8'h61;
        rst = 1'b1;
        apply_stimulus();
        check_output("ill_bbb_flag", 16'(illegal), 16'h1);

        // LDA $8000 with a three-cycle stall in ADDRH and one in MEM
        mem[0] = 8'hAD; mem[1] = 8'h00; mem[2] = 8'h80; mem[16'h8000] = 8'h5A;
        reset_pulse();
        apply_stimulus();
        apply_stimulus();
        check_output("stall_addrh_addr", addr, 16'h0002);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            apply_stimulus();
            check_output($sformatf("stall%0d_addr", i), addr, 16'h0002);
            check_output($sformatf("stall%0d_exec", i), 16'(exec), 16'h0);
        end
        rdy = 1'b1;
        apply_stimulus();
        check_output("stall_mem_addr", addr, 16'h8000);
        check_output("stall_mem_exec", 16'(exec), 16'h1);
        check_output("stall_mem_aluop", 16'(alu_op), 16'h5);
        check_output("stall_mem_operand", 16'(operand), 16'h5A);
        rdy = 1'b0;
        #1;
        check_output("stall_in_mem_exec", 16'(exec), 16'h0);
        check_output("stall_in_mem_addr", addr, 16'h8000);
        apply_stimulus();
        rdy = 1'b1;
        #1;
        check_output("resume_mem_exec", 16'(exec), 16'h1);
        apply_stimulus();
        check_output("stall_done_addr", addr, 16'h0003);
        check_output("stall_done_sync", 16'(sync), 16'h1);

        // LDA #$11 from $FFFF wraps the program counter
        mem_w[16'hFFFF] = 8'hA9; mem_w[0] = 8'h11;
        reset_pulse();
        check_output("wrap_c1_addr", w_addr, 16'hFFFF);
        apply_stimulus();
        check_output("wrap_c2_addr", w_addr, 16'h0000);
        check_output("wrap_c2_exec", 16'(w_exec), 16'h1);
        check_output("wrap_c2_operand", 16'(w_operand), 16'h11);
        apply_stimulus();
        check_output("wrap_c3_addr", w_addr, 16'h0001);
        check_output("wrap_c3_sync", 16'(w_sync), 16'h1);

        $display("[TB] %0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
